// File: rtl/ddr4_rd_arbiter.sv
// Round-robin arbiter sharing one single-beat DDR4 AXI read port among NUM_REQ readers.
// Define DDR4_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins).
//
// state | meaning
// IDLE  | no AR presented to DDR4 (m_arvalid = 0)
// ISSUE | AR presented, waiting for or taking m_arready (m_arvalid = 1)
module ddr4_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 512
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ADDR_W-1:0]                      req_araddr [NUM_REQ],
  input  logic [NUM_REQ-1:0]                     req_arvalid,
  output logic [NUM_REQ-1:0]                     req_arready,
  output logic [DATA_W-1:0]                      req_rdata,
  output logic [NUM_REQ-1:0]                     req_rvalid,
  input  logic [NUM_REQ-1:0]                     req_rready,
  output logic [ADDR_W-1:0]                      m_araddr,
  output logic [7:0]                             m_arlen,
  output logic [2:0]                             m_arsize,
  output logic [1:0]                             m_arburst,
  output logic                                   m_arvalid,
  input  logic                                   m_arready,
  input  logic [DATA_W-1:0]                      m_rdata,
  input  logic                                   m_rvalid,
  output logic                                   m_rready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   protocol_err
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state;
  logic [TAG_W-1:0]   last_grant;
  logic [TAG_W-1:0]   win;
  logic [TAG_W-1:0]   head;
  logic               found;
  logic               slot_free;
  logic               grant;
  logic               fifo_empty;
  logic               pop;
  logic [TAG_W-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  assign m_arlen     = 8'd0;
  assign m_arsize    = 3'b110;
  assign m_arburst   = 2'b01;
  assign m_arvalid   = (state == ISSUE);
  assign outstanding = count;
  assign req_rdata   = m_rdata;

  // Uses the registered count, so a pop in the same cycle cannot open a slot.
  assign slot_free = (!m_arvalid || m_arready) && (count < CNT_W'(MAX_OUTSTANDING));
  assign grant     = slot_free && found;

  always_comb begin : pick
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef DDR4_ARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = (int'(last_grant) + 1 + i) % NUM_REQ;
`endif
      if (!found && req_arvalid[idx]) begin
        found = 1'b1;
        win   = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    req_arready = '0;
    if (grant) req_arready[win] = 1'b1;
  end

  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr];

  always_comb begin
    req_rvalid = '0;
    m_rready   = 1'b0;
    if (!fifo_empty) begin
      req_rvalid[head] = m_rvalid;
      m_rready         = req_rready[head];
    end
  end

  assign pop = m_rvalid && m_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m_araddr   <= '0;
      last_grant <= TAG_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= ISSUE;
            m_araddr   <= req_araddr[win];
            last_grant <= win;
          end
        end
        ISSUE: begin
          if (grant) begin
            m_araddr   <= req_araddr[win];
            last_grant <= win;
          end else if (m_arready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (fifo_empty && m_rvalid) protocol_err <= 1'b1;
    end
  end

endmodule

// File: doc/ddr4_rd_arbiter.md
# ddr4_rd_arbiter

Round-robin arbiter that shares the single DDR4 AXI read port among `NUM_REQ` single-beat readers: the measurement reader, state/covariance readers and similar. Each requester presents an AR request and receives its own R beat back. Beats are routed through an in-order tag FIFO, since the DDR4 port returns reads in issue order and has no ID. The block sits between the per-stream reader FSMs and the DDR4 controller AXI read channels.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_OUTSTANDING`, 8: depth of the tag FIFO; maximum ARs issued but not yet answered (power of two, ≥2).
- `ADDR_W`, 32: address width.
- `DATA_W`, 512: read data width.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_araddr`  in  ADDR_W [NUM_REQ]  per-requester read address.
- `req_arvalid`  in  NUM_REQ  per-requester AR valid; held until its ready.
- `req_arready`  out  NUM_REQ  one-hot grant; combinational.
- `req_rdata`  out  DATA_W  broadcast of `m_rdata`.
- `req_rvalid`  out  NUM_REQ  one-hot R valid for the head-tag owner.
- `req_rready`  in  NUM_REQ  per-requester R ready.
- `m_araddr`  out  ADDR_W  registered.
- `m_arlen`  out  8  constant 0.
- `m_arsize`  out  3  constant 3'b110.
- `m_arburst`  out  2  constant 2'b01.
- `m_arvalid`  out  1  registered.
- `m_arready`  in  1
- `m_rdata`  in  DATA_W
- `m_rvalid`  in  1
- `m_rready`  out  1  combinational.
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  current tag count.
- `protocol_err`  out  1  sticky; set when an R beat arrives with no tag outstanding.

## Operation
- **Slot free:** `slot_free = (!m_arvalid || m_arready) && (outstanding < MAX_OUTSTANDING)`.
- **Grant:** in any cycle with `slot_free` and at least one `req_arvalid`, winner `w` is the first valid index searching from `last_grant+1` modulo `NUM_REQ`.
  - `req_arready[w]` is high in that cycle.
  - On the clock edge: `m_araddr <= req_araddr[w]`, `m_arvalid <= 1`, push tag `w`, `last_grant <= w`.
- **No grant:** when `m_arvalid && m_arready` and there is no new grant, `m_arvalid <= 0`. While `m_arvalid && !m_arready`, `m_araddr` and `m_arvalid` hold stable.
- **R routing:** with head tag `h` and FIFO non-empty:
  - `req_rvalid[h] = m_rvalid`
  - `m_rready = req_rready[h]`
  - All other `req_rvalid` bits are 0.
  - Pop on `m_rvalid && m_rready`.
- **FIFO empty:** `m_rready = 0` and all `req_rvalid = 0`. If `m_rvalid` is seen in this state, `protocol_err <= 1` until reset.
- **Simultaneous push and pop:** `outstanding` is unchanged. Pointers wrap modulo `MAX_OUTSTANDING`.
- **FIFO full:** no grant is made. A pop in the same cycle does not enable a grant; the grant happens one cycle later.
- **States:** AR issue has two states: `IDLE` (`m_arvalid=0`) and `ISSUE` (`m_arvalid=1`).
  - `IDLE` → `ISSUE` on grant.
  - `ISSUE` → `IDLE` on `m_arready` with no grant.
  - `ISSUE` → `ISSUE` on `m_arready` with a grant (back-to-back issue), or while waiting for `m_arready`.

## Timing
- **Reset values:** `m_arvalid=0`, `m_araddr=0`, FIFO empty, `outstanding=0`, `protocol_err=0`, `last_grant=NUM_REQ-1` (requester 0 wins first), all `req_rvalid=0`, `m_rready=0`.
- **AR latency:** requester arvalid to `m_arvalid` is 1 cycle. Sustained throughput is one AR per cycle while `m_arready` stays high.
- **R path:** zero-latency combinational passthrough. No data register.
- **Reset mid-operation:** all tags are discarded. The DDR4 side must be reset together with this block.

## Configuration
- `DDR4_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest valid index always wins and `last_grant` is ignored.
- Undefined (default): round-robin as described above.

## Test plan
- **Single request:** reset, then req0 arvalid with addr 0x0070_0000 and `m_arready=1`.
  - `req_arready[0]` is high that cycle, `m_araddr=0x0070_0000` the next cycle, `outstanding=1`.
  - An R beat 0xA5… goes to `req_rvalid[0]` only, then `outstanding=0`.
- **Round-robin:** req0..3 all held valid, `m_arready=1`. Grants are 0,1,2,3,0 on consecutive cycles. The R beats return tags in that same order.
- **Fixed priority:** rebuild with `DDR4_ARB_FIXED_PRIO_EN`, repeat the round-robin scenario. Req0 is granted every cycle while its arvalid stays high.
- **Full FIFO:** `m_arready=1` and no R for 8 grants, then:
  - `outstanding=8` and no further `req_arready`.
  - One R pop drops `outstanding` to 7, and the next grant follows 1 cycle later.
- **Backpressure:** `m_arready=0` for 5 cycles.
  - `m_araddr` and `m_arvalid` stay stable and no new grant is made.
  - Separately, with the head owner's `req_rready=0`: `m_rready=0` and data is held until it rises.
- **Error and reset:** `m_rvalid=1` with `outstanding=0` sets `protocol_err=1`, which stays set. Asserting `rst_n=0` mid-burst clears all outputs asynchronously.
